// File: rtl/sampler_trigger.sv
// Hardware trigger and capture sequencer for the sampler write side.
// Arms on request, qualifies a masked match, delays, then gates capture.
module sampler_trigger #(
  parameter int width     = 8,
  parameter int delayBits = 16,
  parameter int countBits = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arm,
  input  logic                 abort,
  input  logic [width-1:0]     sample_in,
  input  logic [width-1:0]     trig_mask,
  input  logic [width-1:0]     trig_value,
  input  logic [1:0]           trig_mode,
  input  logic [delayBits-1:0] delay,
  input  logic                 samp_done,
  output logic                 samp_enable,
  output logic [2:0]           state,
  output logic                 busy,
  output logic                 done,
  output logic                 done_pulse,
  output logic [countBits-1:0] trig_latency
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARMED    = 3'd1,
    S_DELAY    = 3'd2,
    S_CAPTURE  = 3'd3,
    S_COMPLETE = 3'd4
  } state_t;

  localparam logic [1:0] M_LEVEL   = 2'd0;
  localparam logic [1:0] M_RISING  = 2'd1;
  localparam logic [1:0] M_IMMED   = 2'd2;
  localparam logic [1:0] M_FALLING = 2'd3;

  localparam logic [delayBits-1:0] DLY_ONE = 1;
  localparam logic [countBits-1:0] CNT_ONE = 1;

  state_t               st;
  logic [width-1:0]     mask_lat;
  logic [width-1:0]     value_lat;
  logic [1:0]           mode_lat;
  logic [delayBits-1:0] dly_lat;
  logic [delayBits-1:0] dly_cnt;
  logic                 match_prev;
  logic                 guard_clr;

  logic arm_take;
  logic match_live;
  logic match_lat;
  logic trig;

  assign state = st;
  assign busy  = (st == S_ARMED) || (st == S_DELAY) ||
                 (st == S_CAPTURE);
  assign done  = (st == S_COMPLETE);

  assign arm_take = arm && !abort &&
                    ((st == S_IDLE) || (st == S_COMPLETE));

  assign match_live =
    (((sample_in ^ trig_value) & trig_mask) == '0);
  assign match_lat =
    (((sample_in ^ value_lat) & mask_lat) == '0);

  always_comb begin
    trig = 1'b0;
    unique case (mode_lat)
      M_LEVEL:   trig = match_lat;
      M_RISING:  trig = match_lat && !match_prev;
      M_IMMED:   trig = 1'b1;
      M_FALLING: trig = !match_lat && match_prev;
      default:   trig = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st           <= S_IDLE;
      samp_enable  <= 1'b0;
      done_pulse   <= 1'b0;
      trig_latency <= '0;
      match_prev   <= 1'b0;
      dly_cnt      <= '0;
      dly_lat      <= '0;
      mask_lat     <= '0;
      value_lat    <= '0;
      mode_lat     <= M_LEVEL;
      guard_clr    <= 1'b0;
    end else begin
      // the arm cycle feeds the edge history from the new config
      match_prev <= arm_take ? match_live : match_lat;
      done_pulse <= 1'b0;
      if (abort) begin
        st          <= S_IDLE;
        samp_enable <= 1'b0;
      end else begin
        case (st)
          S_IDLE, S_COMPLETE: begin
            if (arm) begin
              st           <= S_ARMED;
              samp_enable  <= 1'b0;
              trig_latency <= '0;
              mask_lat     <= trig_mask;
              value_lat    <= trig_value;
              mode_lat     <= trig_mode;
              dly_lat      <= delay;
            end
          end
          S_ARMED: begin
            if (trig) begin
              if (dly_lat == '0) begin
                st          <= S_CAPTURE;
                samp_enable <= 1'b1;
                guard_clr   <= 1'b0;
              end else begin
                st      <= S_DELAY;
                dly_cnt <= dly_lat - DLY_ONE;
              end
            end else if (trig_latency != '1) begin
              trig_latency <= trig_latency + CNT_ONE;
            end
          end
          S_DELAY: begin
            if (dly_cnt == '0) begin
              st          <= S_CAPTURE;
              samp_enable <= 1'b1;
              guard_clr   <= 1'b0;
            end else begin
              dly_cnt <= dly_cnt - DLY_ONE;
            end
          end
          S_CAPTURE: begin
            // a done left over from a prior run must be seen low first
            if (!samp_done) begin
              guard_clr <= 1'b1;
            end else if (guard_clr) begin
              st         <= S_COMPLETE;
              done_pulse <= 1'b1;
            end
          end
          default: begin
            st          <= S_IDLE;
            samp_enable <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sampler_trigger.sv
// Directed bench for sampler_trigger.
// Second instance uses a 4-bit latency counter for saturation.
module tb_sampler_trigger;

  logic        clk;
  logic        reset;
  logic        arm;
  logic        abort;
  logic [7:0]  sample_in;
  logic [7:0]  trig_mask;
  logic [7:0]  trig_value;
  logic [1:0]  trig_mode;
  logic [15:0] delay;
  logic        samp_done;

  logic        samp_enable;
  logic [2:0]  state;
  logic        busy;
  logic        done;
  logic        done_pulse;
  logic [15:0] trig_latency;

  logic        sat_en;
  logic [2:0]  sat_state;
  logic        sat_busy;
  logic        sat_done;
  logic        sat_dp;
  logic [3:0]  sat_lat;

  int tests = 0;
  int fails = 0;

  sampler_trigger #(
    .width(8), .delayBits(16), .countBits(16)
  ) u_dut (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort),
    .sample_in(sample_in), .trig_mask(trig_mask),
    .trig_value(trig_value), .trig_mode(trig_mode),
    .delay(delay), .samp_done(samp_done),
    .samp_enable(samp_enable), .state(state), .busy(busy),
    .done(done), .done_pulse(done_pulse),
    .trig_latency(trig_latency)
  );

  sampler_trigger #(
    .width(8), .delayBits(16), .countBits(4)
  ) u_sat (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort),
    .sample_in(sample_in), .trig_mask(trig_mask),
    .trig_value(trig_value), .trig_mode(trig_mode),
    .delay(delay), .samp_done(samp_done),
    .samp_enable(sat_en), .state(sat_state), .busy(sat_busy),
    .done(sat_done), .done_pulse(sat_dp),
    .trig_latency(sat_lat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; arm = 1'b1; abort = 1'b0;
    sample_in = 8'h00; trig_mask = 8'h00; trig_value = 8'h00;
    trig_mode = 2'd2; delay = 16'd0; samp_done = 1'b0;
    tick(); tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_misc", {busy, done, done_pulse, samp_enable}, 4'b0000);
    chk("rst_lat", 32'(trig_latency), 32'd0);
    arm = 1'b0;
    reset = 1'b0;
    tick();
    chk("idle_hold", 32'(state), 32'd0);

    // immediate, delay 0
    arm = 1'b1;
    tick();
    chk("imm_armed", 32'(state), 32'd1);
    chk("imm_armed_en", 32'(samp_enable), 32'd0);
    chk("imm_busy", 32'(busy), 32'd1);
    arm = 1'b0;
    tick();
    chk("imm_capture", 32'(state), 32'd3);
    chk("imm_en", 32'(samp_enable), 32'd1);
    chk("imm_lat", 32'(trig_latency), 32'd0);
    tick(); tick(); tick();
    chk("imm_wait", 32'(state), 32'd3);
    samp_done = 1'b1;
    tick();
    chk("imm_complete", 32'(state), 32'd4);
    chk("imm_pulse", {done, done_pulse, samp_enable}, 3'b111);
    tick();
    chk("imm_pulse_off", {done, done_pulse, samp_enable}, 3'b101);
    samp_done = 1'b0;
    arm = 1'b1;
    tick();
    chk("rearm_armed", 32'(state), 32'd1);
    chk("rearm_en_low", 32'(samp_enable), 32'd0);
    chk("rearm_done_low", 32'(done), 32'd0);
    arm = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // level mode, mask 0, mode changed after arm, stale done
    trig_mode = 2'd0; trig_mask = 8'h00; delay = 16'd0;
    tick();
    samp_done = 1'b0;
    arm = 1'b1;
    tick();
    chk("lvl_armed", 32'(state), 32'd1);
    arm = 1'b0;
    trig_mode = 2'd3;
    samp_done = 1'b1;
    tick();
    chk("lvl_capture", 32'(state), 32'd3);
    tick(); tick();
    chk("stale_hold", 32'(state), 32'd3);
    chk("stale_no_done", 32'(done), 32'd0);
    samp_done = 1'b0;
    tick();
    chk("stale_low", 32'(state), 32'd3);
    samp_done = 1'b1;
    tick();
    chk("stale_complete", 32'(state), 32'd4);
    chk("stale_pulse", 32'(done_pulse), 32'd1);
    samp_done = 1'b0;
    tick(); tick();
    chk("complete_hold", 32'(state), 32'd4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_complete", {state, samp_enable, done_pulse}, 5'b00000);

    // rising, mask 0F value 05, delay 3
    trig_mode = 2'd1; trig_mask = 8'h0F; trig_value = 8'h05;
    delay = 16'd3; sample_in = 8'h15;
    arm = 1'b1;
    tick();
    chk("rise_armed", 32'(state), 32'd1);
    arm = 1'b0;
    trig_value = 8'hAA;
    trig_mask = 8'hFF;
    delay = 16'd0;
    tick();
    chk("rise_no_trig", 32'(state), 32'd1);
    sample_in = 8'h00;
    repeat (10) tick();
    chk("rise_still_armed", 32'(state), 32'd1);
    chk("rise_lat_run", 32'(trig_latency), 32'd11);
    sample_in = 8'h25;
    tick();
    chk("rise_delay", 32'(state), 32'd2);
    sample_in = 8'h00;
    tick();
    chk("rise_delay2", 32'(state), 32'd2);
    tick();
    chk("rise_delay3", {state, samp_enable}, {3'd2, 1'b0});
    tick();
    chk("rise_capture", {state, samp_enable}, {3'd3, 1'b1});
    chk("rise_lat", 32'(trig_latency), 32'd11);

    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_cap", {state, samp_enable, done_pulse}, 5'b00000);

    // abort in ARMED
    trig_mode = 2'd1; trig_mask = 8'h00;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("ab_armed_pre", 32'(state), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_armed", {state, samp_enable, done_pulse}, 5'b00000);

    // abort in DELAY
    trig_mode = 2'd2; delay = 16'd5;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    chk("ab_delay_pre", 32'(state), 32'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_delay", {state, samp_enable, done_pulse}, 5'b00000);

    // abort + arm together from IDLE
    abort = 1'b1; arm = 1'b1;
    tick();
    abort = 1'b0; arm = 1'b0;
    chk("abort_arm", 32'(state), 32'd0);
    tick();
    chk("abort_arm2", 32'(state), 32'd0);

    // falling, mask FF value 33, delay 0
    trig_mode = 2'd3; trig_mask = 8'hFF; trig_value = 8'h33;
    delay = 16'd0; sample_in = 8'h33;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    chk("fall_hold", 32'(state), 32'd1);
    sample_in = 8'h34;
    tick();
    chk("fall_capture", 32'(state), 32'd3);
    chk("fall_lat", 32'(trig_latency), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // saturation: rising with mask 0 never fires
    trig_mode = 2'd1; trig_mask = 8'h00;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (20) tick();
    chk("sat_main", 32'(trig_latency), 32'd20);
    chk("sat_4bit", 32'(sat_lat), 32'd15);
    chk("sat_state", 32'(sat_state), 32'd1);
    chk("sat_misc", {sat_en, sat_busy, sat_done, sat_dp}, 4'b0100);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // reset mid-DELAY, with arm held
    trig_mode = 2'd2; delay = 16'd5;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    chk("rstd_pre", 32'(state), 32'd2);
    reset = 1'b1; arm = 1'b1;
    tick();
    chk("rstd_state", 32'(state), 32'd0);
    chk("rstd_misc", {busy, done, done_pulse, samp_enable}, 4'b0000);
    chk("rstd_lat", 32'(trig_latency), 32'd0);
    reset = 1'b0; arm = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
